square_sprite_core: RTL and testbench

SQUARE_SPRITE_CORE -- requirements
Module: square_sprite_core

---
 rtl/square_sprite_core_pkg.sv | 30 +++
 rtl/square_sprite_core.sv | 105 ++++++++++
 tb/tb_square_sprite_core.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/square_sprite_core_pkg.sv
// square_sprite_core_pkg: shared constants and types for the square sprite overlay core.
// Revision: 1.0
`default_nettype none

package square_sprite_core_pkg;

  localparam int COLOR_DEPTH = 12;
  localparam int SPRITE_SIZE = 32;
  localparam int SPRITE_BITS = 5;
  localparam int COORD_WIDTH = 11;

  localparam logic [2:0] REG_X0   = 3'd0;
  localparam logic [2:0] REG_Y0   = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd2;
  localparam logic [2:0] REG_PAL1 = 3'd3;
  localparam logic [2:0] REG_PAL2 = 3'd4;
  localparam logic [2:0] REG_PAL3 = 3'd5;

  localparam logic [11:0] PAL1_RST = 12'hF00;
  localparam logic [11:0] PAL2_RST = 12'h0F0;
  localparam logic [11:0] PAL3_RST = 12'hFFF;

  typedef struct packed {
    logic blink_en;
    logic bypass;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/square_sprite_core.sv
// square_sprite_core: 32x32 palette sprite composited over an upstream pixel stream.
// Revision: 1.0
`default_nettype none

module square_sprite_core
  import square_sprite_core_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2,
  parameter int CD         = COLOR_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            x,
  input  logic [10:0]            y,
  input  logic                   frame_start,
  input  logic [CD-1:0]          si_rgb,
  input  logic                   wr_en,
  input  logic [10:0]            wr_addr,
  input  logic [CD-1:0]          wr_data,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr_w,
  output logic [DATA_WIDTH-1:0]  ram_din,
  output logic [ADDR_WIDTH-1:0]  ram_addr_r,
  input  logic [DATA_WIDTH-1:0]  ram_dout,
  output logic [CD-1:0]          so_rgb
);

  logic [COORD_WIDTH-1:0] x0, y0, x0_pend, y0_pend;
  logic [COORD_WIDTH-1:0] dx, dy;
  ctrl_t                  ctrl;
  logic [CD-1:0]          pal1, pal2, pal3;
  logic [5:0]             blink_cnt;
  logic                   hit, hit_d1;
  logic [CD-1:0]          si_rgb_d1;
  logic                   reg_we;
  logic                   hidden;
  logic                   show;
  logic [CD-1:0]          pal_color;

  // The RAM write port is a pure decode of the bus so writes land the same cycle.
  assign ram_we     = wr_en & wr_addr[10];
  assign ram_addr_w = wr_addr[ADDR_WIDTH-1:0];
  assign ram_din    = wr_data[DATA_WIDTH-1:0];
  assign reg_we     = wr_en & ~wr_addr[10];

  assign dx  = x - x0;
  assign dy  = y - y0;
  assign hit = (dx[COORD_WIDTH-1:SPRITE_BITS] == '0) && (dy[COORD_WIDTH-1:SPRITE_BITS] == '0);
  assign ram_addr_r = ADDR_WIDTH'({dy[SPRITE_BITS-1:0], dx[SPRITE_BITS-1:0]});

  assign hidden = ctrl.blink_en & blink_cnt[5];
  assign show   = hit_d1 & ~ctrl.bypass & ~hidden & (ram_dout != '0);

  always_comb begin
    pal_color = si_rgb_d1;
    case (ram_dout)
      DATA_WIDTH'(1): pal_color = pal1;
      DATA_WIDTH'(2): pal_color = pal2;
      DATA_WIDTH'(3): pal_color = pal3;
      default:        pal_color = si_rgb_d1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0        <= '0;
      y0        <= '0;
      x0_pend   <= '0;
      y0_pend   <= '0;
      ctrl      <= '0;
      pal1      <= CD'(PAL1_RST);
      pal2      <= CD'(PAL2_RST);
      pal3      <= CD'(PAL3_RST);
      blink_cnt <= '0;
      hit_d1    <= 1'b0;
      si_rgb_d1 <= '0;
      so_rgb    <= '0;
    end else begin
      if (reg_we) begin
        case (wr_addr[2:0])
          REG_X0:   x0_pend <= COORD_WIDTH'(wr_data);
          REG_Y0:   y0_pend <= COORD_WIDTH'(wr_data);
          REG_CTRL: ctrl    <= ctrl_t'(wr_data[1:0]);
          REG_PAL1: pal1    <= wr_data;
          REG_PAL2: pal2    <= wr_data;
          REG_PAL3: pal3    <= wr_data;
          default:  ;
        endcase
      end
      // Position commits only at frame start, using the pending value from before this edge.
      if (frame_start) begin
        x0        <= x0_pend;
        y0        <= y0_pend;
        blink_cnt <= blink_cnt + 6'd1;
      end
      hit_d1    <= hit;
      si_rgb_d1 <= si_rgb;
      so_rgb    <= show ? pal_color : si_rgb_d1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_square_sprite_core.sv
// tb_square_sprite_core: directed scoreboard bench for square_sprite_core with a behavioural sprite RAM.
// Revision: 1.0
`default_nettype none

module tb_square_sprite_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x, y;
  logic        frame_start;
  logic [11:0] si_rgb;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [11:0] wr_data;
  logic        ram_we;
  logic [9:0]  ram_addr_w, ram_addr_r;
  logic [1:0]  ram_din, ram_dout;
  logic [11:0] so_rgb;

  always #5 clk = ~clk;

  square_sprite_core #(.ADDR_WIDTH(10), .DATA_WIDTH(2), .CD(12)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_start(frame_start),
    .si_rgb(si_rgb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_we(ram_we), .ram_addr_w(ram_addr_w), .ram_din(ram_din),
    .ram_addr_r(ram_addr_r), .ram_dout(ram_dout), .so_rgb(so_rgb)
  );

  logic [1:0] mem [1024];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_w] <= ram_din;
    ram_dout <= mem[ram_addr_r];
  end

  logic        pix_v = 1'b0, v1 = 1'b0, v2 = 1'b0, rst_d = 1'b0;
  logic        end_chk = 1'b0, end_done = 1'b0;
  logic [11:0] exp_q [$];
  logic [11:0] exp_now;
  int          vectors = 0, miscompares = 0;

  // Output-valid tag follows the two-stage pipeline; reset drops anything in flight.
  always @(posedge clk) begin
    rst_d <= !rst_n;
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= pix_v;
      v2 <= v1;
    end
  end

  always @(negedge clk) begin
    if (rst_d) begin
      vectors++;
      if (so_rgb !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_so_rgb: got %h expected %h", so_rgb, 12'h000);
      end
    end
    if (v2) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pixel: got %h expected no output", so_rgb);
      end else begin
        exp_now = exp_q.pop_front();
        if (so_rgb !== exp_now) begin
          miscompares++;
          $display("FAIL pixel_%0d: got %h expected %h", vectors, so_rgb, exp_now);
        end
      end
    end
    if (end_chk && !end_done) begin
      end_done = 1'b1;
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    wr_en       = 1'b0;
    frame_start = 1'b0;
    pix_v       = 1'b0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [11:0] d);
    cyc();
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic fs();
    cyc();
    frame_start = 1'b1;
  endtask

  task automatic pix(input int px, input int py, input logic [11:0] bg, input logic [11:0] e);
    cyc();
    x      = 11'(px);
    y      = 11'(py);
    si_rgb = bg;
    pix_v  = 1'b1;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; x = '0; y = '0; frame_start = 1'b0; si_rgb = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) cyc();
    rst_n = 1'b1;

    for (int i = 0; i < 1024; i++) wr(11'h400 | 11'(i), 12'h001);

    // Basic placement and edges of the 32x32 box
    wr(11'd0, 12'd100);
    wr(11'd1, 12'd50);
    fs();
    pix(100, 50, 12'h00F, 12'hF00);
    pix(99,  50, 12'h00F, 12'h00F);
    pix(132, 50, 12'h00F, 12'h00F);
    pix(131, 81, 12'h0AA, 12'hF00);
    pix(100, 82, 12'h0AA, 12'h0AA);

    // Position changes wait for frame_start
    wr(11'd0, 12'd200);
    pix(100, 50, 12'h00F, 12'hF00);
    pix(200, 50, 12'h00F, 12'h00F);
    fs();
    pix(200, 50, 12'h00F, 12'hF00);
    pix(100, 50, 12'h00F, 12'h00F);
    cyc();
    frame_start = 1'b1; wr_en = 1'b1; wr_addr = 11'd0; wr_data = 12'd300;
    pix(200, 50, 12'h00F, 12'hF00);
    pix(300, 50, 12'h00F, 12'h00F);
    fs();
    pix(300, 50, 12'h00F, 12'hF00);

    // Transparency and palette updates at {dy=3,dx=7}
    wr(11'h467, 12'h000);
    pix(307, 53, 12'h123, 12'h123);
    pix(306, 53, 12'h123, 12'hF00);
    wr(11'd4, 12'hABC);
    wr(11'h467, 12'h002);
    pix(307, 53, 12'h123, 12'hABC);
    wr(11'd5, 12'h5A5);
    wr(11'h467, 12'h003);
    pix(307, 53, 12'h123, 12'h5A5);
    wr(11'h467, 12'h002);
    wr(11'd6, 12'h777);
    pix(307, 53, 12'h123, 12'hABC);

    // Blink: counter is 4 here after four frame_start pulses
    wr(11'd2, 12'h002);
    pix(300, 50, 12'h00F, 12'hF00);
    repeat (28) fs();
    pix(300, 50, 12'h00F, 12'h00F);
    repeat (31) fs();
    pix(300, 50, 12'h00F, 12'h00F);
    fs();
    pix(300, 50, 12'h00F, 12'hF00);
    wr(11'd2, 12'h000);

    // Coordinate wrap and bypass
    wr(11'd0, 12'd2040);
    wr(11'd1, 12'd50);
    fs();
    pix(5,    50, 12'h00F, 12'hF00);
    pix(2039, 50, 12'h00F, 12'h00F);
    pix(19,   50, 12'h00F, 12'hF00);
    pix(24,   50, 12'h00F, 12'h00F);
    wr(11'd2, 12'h001);
    pix(5,    50, 12'h00F, 12'h00F);
    pix(2040, 50, 12'h0F0, 12'h0F0);
    wr(11'd2, 12'h000);

    // Mid-sprite reset drops the in-flight pixel and restores registers, not RAM
    cyc();
    x = 11'd5; y = 11'd50; si_rgb = 12'h00F;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    fs();
    pix(7,    3,  12'h00F, 12'h0F0);
    pix(0,    0,  12'h00F, 12'hF00);
    pix(5,    50, 12'h00F, 12'h00F);
    pix(2040, 50, 12'h00F, 12'h00F);

    repeat (4) cyc();
    end_chk = 1'b1;
    cyc();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
